// File: rtl/mac_mul_sign_restorer_pkg.sv
// Shared constants and helpers for the MAC sign restorer.
// Holds the cfg field layout, the mode encodings, the bus widths, and the
// mapping from the four per-byte negative flags onto the four 16-bit
// negation segments.
package mac_mul_sign_restorer_pkg;

  localparam int MAC_CONF_WIDTH     = 4;
  localparam int MAC_MIN_WIDTH      = 8;
  localparam int MAC_MULT_WIDTH     = 2 * MAC_MIN_WIDTH;
  localparam int MAC_PROD_WIDTH     = 4 * MAC_MULT_WIDTH;
  localparam int MAC_CFG_SIGNED_BIT = 3;

  localparam logic [1:0] MAC_CFG_MODE_SINGLE = 2'b00;
  localparam logic [1:0] MAC_CFG_MODE_DUAL   = 2'b01;
  localparam logic [1:0] MAC_CFG_MODE_QUAD   = 2'b10;

  typedef enum logic [1:0] {
    LANE_SINGLE,
    LANE_DUAL,
    LANE_QUAD
  } lane_mode_e;

  // The unused encoding 2'b11 behaves as single mode.
  function automatic lane_mode_e decode_mode(input logic [1:0] mode);
    lane_mode_e m;
    case (mode)
      MAC_CFG_MODE_DUAL:   m = LANE_DUAL;
      MAC_CFG_MODE_QUAD:   m = LANE_QUAD;
      MAC_CFG_MODE_SINGLE: m = LANE_SINGLE;
      default:             m = LANE_SINGLE;
    endcase
    return m;
  endfunction

  // Per-segment negate enables. A wide lane takes the flag of its most
  // significant byte position, so every segment of that lane sees the same bit.
  function automatic logic [3:0] seg_neg_map(input lane_mode_e mode,
                                             input logic       sgn,
                                             input logic [3:0] flags);
    logic [3:0] m;
    case (mode)
      LANE_DUAL: m = {flags[3], flags[3], flags[1], flags[1]};
      LANE_QUAD: m = {4{flags[3]}};
      default:   m = flags;
    endcase
    return m & {4{sgn}};
  endfunction

endpackage

// File: rtl/mac_seg_negate.sv
// One 16-bit segment of the segmented two's-complement negator.
// Ports:
//   x    - magnitude segment
//   cin  - carry into the ~x adder (1 at a lane's low segment)
//   neg  - select the negated value instead of x
//   y    - segment result
//   cout - carry out of ~x + cin, chained to the next segment of a wide lane
module mac_seg_negate
  import mac_mul_sign_restorer_pkg::*;
(
  input  logic [MAC_MULT_WIDTH-1:0] x,
  input  logic                      cin,
  input  logic                      neg,
  output logic [MAC_MULT_WIDTH-1:0] y,
  output logic                      cout
);

  logic [MAC_MULT_WIDTH:0] sum;

  assign sum  = {1'b0, ~x} + {{MAC_MULT_WIDTH{1'b0}}, cin};
  assign y    = neg ? sum[MAC_MULT_WIDTH-1:0] : x;
  assign cout = sum[MAC_MULT_WIDTH];

endmodule

// File: rtl/mac_mul_sign_restorer.sv
// Re-applies the product sign after the unsigned magnitude multiplier.
// Stage 1 registers the magnitude bus, the per-segment negate vector and cfg;
// stage 2 registers the conditionally negated result.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en                - global enable; 0 freezes every register
//   cfg               - [3] signed, [2] mac/mul (passed through), [1:0] mode
//   in_valid/in_ready - input handshake for P_in, C*_neg, cfg
//   P_in              - lane-packed unsigned magnitude products
//   C0_neg..C3_neg    - per-byte negative-result flags
//   out_valid/out_ready - output handshake
//   R_out, cfg_out    - two's-complement lane results and aligned cfg
module mac_mul_sign_restorer
  import mac_mul_sign_restorer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAC_PROD_WIDTH-1:0] P_in,
  input  logic                      C0_neg,
  input  logic                      C1_neg,
  input  logic                      C2_neg,
  input  logic                      C3_neg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_PROD_WIDTH-1:0] R_out,
  output logic [MAC_CONF_WIDTH-1:0] cfg_out
);

  localparam int W = MAC_MULT_WIDTH;

  logic                      s1_valid;
  logic [MAC_PROD_WIDTH-1:0] s1_p;
  logic [3:0]                s1_neg;
  logic [MAC_CONF_WIDTH-1:0] s1_cfg;

  logic                      s2_valid;
  logic [MAC_PROD_WIDTH-1:0] s2_r;
  logic [MAC_CONF_WIDTH-1:0] s2_cfg;

  logic s2_adv;
  logic in_fire;
  logic out_fire;
  logic [3:0] in_neg;

  // Handshake: stage 2 frees up when empty or being drained this cycle.
  assign s2_adv   = en & s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign in_fire  = en & in_valid & in_ready;
  assign out_fire = en & s2_valid & out_ready;

  assign in_neg = seg_neg_map(decode_mode(cfg[1:0]), cfg[MAC_CFG_SIGNED_BIT],
                              {C3_neg, C2_neg, C1_neg, C0_neg});

  // Segmented carry chain: a carry only crosses a segment boundary that lies
  // inside a lane (1->2 only in quad; 0->1 and 2->3 in dual and quad).
  lane_mode_e s1_mode;
  logic       cin1, cin2, cin3;
  logic       cout0, cout1, cout2;
  logic       seg3_cout_unused;  // carry out of the top of the 64-bit bus
  logic [MAC_PROD_WIDTH-1:0] neg_result;

  assign s1_mode = decode_mode(s1_cfg[1:0]);
  assign cin1    = (s1_mode == LANE_SINGLE) ? 1'b1 : cout0;
  assign cin2    = (s1_mode == LANE_QUAD)   ? cout1 : 1'b1;
  assign cin3    = (s1_mode == LANE_SINGLE) ? 1'b1 : cout2;

  mac_seg_negate u_seg0 (
    .x(s1_p[W-1:0]),     .cin(1'b1), .neg(s1_neg[0]),
    .y(neg_result[W-1:0]),     .cout(cout0)
  );
  mac_seg_negate u_seg1 (
    .x(s1_p[2*W-1:W]),   .cin(cin1), .neg(s1_neg[1]),
    .y(neg_result[2*W-1:W]),   .cout(cout1)
  );
  mac_seg_negate u_seg2 (
    .x(s1_p[3*W-1:2*W]), .cin(cin2), .neg(s1_neg[2]),
    .y(neg_result[3*W-1:2*W]), .cout(cout2)
  );
  mac_seg_negate u_seg3 (
    .x(s1_p[4*W-1:3*W]), .cin(cin3), .neg(s1_neg[3]),
    .y(neg_result[4*W-1:3*W]), .cout(seg3_cout_unused)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared as well as the valids, so R_out and
      // cfg_out read as zero after reset rather than holding stale lanes.
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_neg   <= '0;
      s1_cfg   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_p     <= P_in;
      s1_neg   <= in_neg;
      s1_cfg   <= cfg;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_cfg   <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_r     <= neg_result;
      s2_cfg   <= s1_cfg;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign R_out     = s2_r;
  assign cfg_out   = s2_cfg;

endmodule

// File: tb/tb_mac_mul_sign_restorer.sv
// Self-checking bench for mac_mul_sign_restorer: directed vector table with
// hand-computed results, plus backpressure, enable-freeze and mid-stream reset
// sequences.
module tb_mac_mul_sign_restorer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  cfg;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] P_in;
  logic        C0_neg, C1_neg, C2_neg, C3_neg;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] R_out;
  logic [3:0]  cfg_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  cfg;
    logic [63:0] p;
    logic [3:0]  c;      // {C3, C2, C1, C0}
    logic [63:0] exp_r;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  mac_mul_sign_restorer dut (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg),
    .in_valid(in_valid), .in_ready(in_ready), .P_in(P_in),
    .C0_neg(C0_neg), .C1_neg(C1_neg), .C2_neg(C2_neg), .C3_neg(C3_neg),
    .out_valid(out_valid), .out_ready(out_ready),
    .R_out(R_out), .cfg_out(cfg_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cfg  = v.cfg;
    P_in = v.p;
    {C3_neg, C2_neg, C1_neg, C0_neg} = v.c;
  endtask

  initial begin
    int sent;
    int got;
    logic acc;

    vecs[0]  = '{4'b1000, 64'h4000_0000_0080_0006, 4'b0111, 64'h4000_0000_FF80_FFFA};
    vecs[1]  = '{4'b1001, 64'h0000_0005_0001_0000, 4'b0111, 64'h0000_0005_FFFF_0000};
    vecs[2]  = '{4'b1010, 64'h0000_0000_0000_0001, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3]  = '{4'b1010, 64'h0000_0000_0000_0000, 4'b1000, 64'h0000_0000_0000_0000};
    vecs[4]  = '{4'b0010, 64'h1234_5678_9ABC_DEF0, 4'b1111, 64'h1234_5678_9ABC_DEF0};
    vecs[5]  = '{4'b1011, 64'h0001_0002_0003_0004, 4'b1010, 64'hFFFF_0002_FFFD_0004};
    vecs[6]  = '{4'b1001, 64'h0000_0001_0000_0007, 4'b1000, 64'hFFFF_FFFF_0000_0007};
    vecs[7]  = '{4'b1010, 64'h0123_4567_89AB_CDEF, 4'b0111, 64'h0123_4567_89AB_CDEF};
    vecs[8]  = '{4'b1010, 64'h0000_0000_0001_0000, 4'b1000, 64'hFFFF_FFFF_FFFF_0000};
    vecs[9]  = '{4'b1000, 64'h0000_0000_0001_0000, 4'b0011, 64'h0000_0000_FFFF_0000};
    vecs[10] = '{4'b1001, 64'h0000_0001_0000_0000, 4'b1010, 64'hFFFF_FFFF_0000_0000};

    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cfg = '0; P_in = '0; {C3_neg, C2_neg, C1_neg, C0_neg} = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset R_out",     R_out,     0);
    check("reset cfg_out",   cfg_out,   0);
    check("reset in_ready",  in_ready,  1);
    tick();

    // Directed vectors, one at a time, latency checked on each.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check($sformatf("v%0d in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      check($sformatf("v%0d out_valid@1", i), out_valid, 0);
      tick();
      #1;
      check($sformatf("v%0d out_valid@2", i), out_valid, 1);
      check($sformatf("v%0d R_out", i), R_out, vecs[i].exp_r);
      check($sformatf("v%0d cfg_out", i), cfg_out, {60'd0, vecs[i].cfg});
      tick();
    end

    // Backpressure: fill both stages with the sink stalled.
    out_ready = 1'b0;
    drive(vecs[0]); in_valid = 1'b1;
    #1;
    check("bp in_ready 0", in_ready, 1);
    tick();
    drive(vecs[1]);
    #1;
    check("bp in_ready 1", in_ready, 1);
    tick();
    drive(vecs[2]);
    #1;
    check("bp in_ready drop", in_ready, 0);
    check("bp out_valid", out_valid, 1);
    check("bp R_out first", R_out, vecs[0].exp_r);
    tick();
    #1;
    check("bp in_ready held", in_ready, 0);
    check("bp R_out stable", R_out, vecs[0].exp_r);
    check("bp cfg_out stable", cfg_out, {60'd0, vecs[0].cfg});

    // en=0 freezes everything even with the sink ready.
    en = 1'b0;
    out_ready = 1'b1;
    #1;
    check("en0 in_ready", in_ready, 0);
    tick();
    #1;
    check("en0 out_valid", out_valid, 1);
    check("en0 R_out frozen", R_out, vecs[0].exp_r);
    en = 1'b1;

    // Drain: collect all four results in order while sending the rest.
    sent = 2;
    got  = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      in_valid = (sent < 4);
      if (sent < 4) drive(vecs[sent]);
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("bp order R_out %0d", got), R_out, vecs[got].exp_r);
        check($sformatf("bp order cfg_out %0d", got), cfg_out, {60'd0, vecs[got].cfg});
        got++;
      end
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check("bp results count", got, 4);
    check("bp inputs sent", sent, 4);
    #1;
    check("bp no dup 0", out_valid, 0);
    tick();
    #1;
    check("bp no dup 1", out_valid, 0);
    tick();

    // Reset mid-stream with both stages occupied.
    out_ready = 1'b0;
    drive(vecs[4]); in_valid = 1'b1;
    tick();
    drive(vecs[5]);
    tick();
    in_valid = 1'b0;
    #1;
    check("mid full out_valid", out_valid, 1);
    check("mid full in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid rst out_valid", out_valid, 0);
    check("mid rst R_out", R_out, 0);
    check("mid rst cfg_out", cfg_out, 0);
    check("mid rst in_ready", in_ready, 1);
    out_ready = 1'b1;
    drive(vecs[6]); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("post rst out_valid@1", out_valid, 0);
    tick();
    #1;
    check("post rst out_valid@2", out_valid, 1);
    check("post rst R_out", R_out, vecs[6].exp_r);
    tick();
    #1;
    check("post rst drained", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_mul_sign_restorer.md
Name: mac_mul_sign_restorer

Overview:
Re-applies the product sign after the unsigned magnitude multiplier array, completing the sign-magnitude path opened by the operand negator.
- Takes the magnitude product bus, the four per-byte negative flags (C0..C3_neg) and the lane config.
- Emits two's-complement lane results to the accumulator.
- Two-stage valid/ready pipeline with a configurable segmented negation carry chain (single / dual / quad).

Parameters:
MAC_CONF_WIDTH, 4, cfg width: [3] signed, [2] mac/mul (passed through), [1:0] mode
MAC_MIN_WIDTH, 8, minimum operand width
MAC_MULT_WIDTH, 2*MAC_MIN_WIDTH, single-mode product width; also the negation segment width
MAC_PROD_WIDTH, 4*MAC_MULT_WIDTH, full product bus width (64)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  global enable; when 0 no transfer occurs and all registers hold
cfg  in  MAC_CONF_WIDTH  config sampled with P_in
in_valid  in  1  P_in / C*_neg / cfg valid
in_ready  out  1  stage 1 can accept
P_in  in  MAC_PROD_WIDTH  unsigned magnitude products, lane-packed
C0_neg..C3_neg  in  1 each  negative-result flags from the negator
out_valid  out  1  R_out valid
out_ready  in  1  downstream accepts
R_out  out  MAC_PROD_WIDTH  signed lane results
cfg_out  out  MAC_CONF_WIDTH  cfg aligned with R_out

Behaviour:
- Mode decode:
  - quad = cfg[1:0]==2'b10
  - dual = 2'b01
  - single = otherwise (including 2'b11)
- Lanes:
  - single: four 16-bit lanes P[16i+15:16i], lane i uses Ci_neg.
  - dual: two 32-bit lanes, low lane uses C1_neg, high lane uses C3_neg; C0 and C2 are ignored.
  - quad: one 64-bit lane using C3_neg; C0..C2 are ignored.
- Negation: lane_neg = flag & cfg[3]. Negated lane = ~P + 1, computed over four 16-bit segments.
  - Segment 0 cin = 1.
  - Segment 1 cin = single ? 1 : seg0 cout.
  - Segment 2 cin = quad ? seg1 cout : 1.
  - Segment 3 cin = single ? 1 : seg2 cout.
  - A segment outputs the negated value when its lane_neg is set, else P unchanged.
- cfg[3]=0: R_out = P_in bit-exact, regardless of flags.
- Zero magnitude with flag set gives 0 (the carry-out wraps). Magnitude 0x0080 with neg gives 0xFF80 (-128); no saturation, modular arithmetic only.
- Pipeline, stage 1 (s1): registers P_in, the lane_neg vector and cfg.
- Pipeline, stage 2 (s2): registers the conditionally negated result and cfg; drives R_out, cfg_out and out_valid.
- Latency: 2 cycles from accepted input to out_valid with no stall. Throughput is 1 per cycle.
- Handshake:
  - s2_adv = en & s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s2_adv.
  - An input transfer happens when en & in_valid & in_ready.
  - An output transfer happens when out_valid & out_ready.
  - A consumed s2 with no s2_adv clears s2_valid.
  - Simultaneous accept and advance in the same cycle is legal (full-rate).
- Stability: while out_valid & ~out_ready, R_out and cfg_out are held stable. in_valid may drop at any time without affecting already-accepted data.
- en=0: in_ready is still driven, but no register updates and no transfer occurs.
- Reset, applied on any cycle including mid-stream, drops all in-flight data:
  - s1_valid = 0, out_valid = 0
  - R_out = 0, cfg_out = 0, all data registers = 0
  - in_ready = 1 after reset

Decomposition:
- mac_const.vh gains:
  - MAC_CFG_SIGNED_BIT = 3
  - MAC_CFG_MODE_SINGLE / DUAL / QUAD encodings
  - MAC_PROD_WIDTH
- Sub-module mac_seg_negate: a MAC_MULT_WIDTH-bit ~x+cin adder with cout and a neg select mux. It is instantiated 4 times by the top level, which owns the carry-chain muxing, the flag-to-lane mapping and the pipeline registers.

Test Plan:
- Single signed: cfg=4'b1000, P=0x4000_0000_0080_0006, C3..C0=0,1,1,1 -> after 2 cycles R_out=0x4000_0000_FF80_FFFA.
- Dual signed: cfg=4'b1001, P=0x0000_0005_0001_0000, C0=1, C1=1, C2=1, C3=0 -> R_out=0x0000_0005_FFFF_0000 (C0 and C2 ignored).
- Quad full carry: cfg=4'b1010, P=0x0000_0000_0000_0001, C3=1 -> R_out=0xFFFF_FFFF_FFFF_FFFF. With P=0 and C3=1 -> R_out=0.
- Unsigned passthrough: cfg=4'b0010, P=0x1234_5678_9ABC_DEF0, all C=1 -> R_out=0x1234_5678_9ABC_DEF0, cfg_out=4'b0010.
- Backpressure: 4 back-to-back inputs, out_ready=0 for 3 cycles.
  - in_ready drops after 2 inputs are accepted.
  - R_out is stable while stalled.
  - All 4 results emerge in order with no loss or duplication.
  - en=0 for 1 cycle freezes all state.
- Reset mid-stream: with s1 and s2 both valid, assert rst for 1 cycle -> next cycle out_valid=0, R_out=0, in_ready=1. The first post-reset input appears 2 cycles after acceptance.
